// File: rtl/param_step_pkg.sv
// Shared types and mode constants for the parameterised step counter.
package param_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SAT   = 2'd2
  } state_t;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;

endpackage

// File: rtl/param_step_addsat.sv
// Combinational step: adds INC to the current value in WIDTH+1 bits, flags
// out-of-range results and applies the wrap or clamp policy.
module param_step_addsat
  import param_step_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INC         = 1,
  parameter int SIGNED_MODE = MODE_UNSIGNED,
  parameter int SATURATE    = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] next_val,
  output logic             out_of_range
);

  localparam longint          INC_L   = INC;
  localparam logic [WIDTH:0]  INC_EXT = INC_L[WIDTH:0];
  localparam bit              INC_NEG = (INC < 0);

  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] clamp;

  // Unsigned: INC fits in WIDTH signed bits, so bit WIDTH of the sum is set
  // exactly when the true result is above the max or below zero.
  always_comb begin
    cur_ext      = (SIGNED_MODE == MODE_SIGNED) ? {cur[WIDTH-1], cur} : {1'b0, cur};
    sum          = cur_ext + INC_EXT;
    out_of_range = 1'b0;
    clamp        = '0;
    if (SIGNED_MODE == MODE_SIGNED) begin
      out_of_range = sum[WIDTH] ^ sum[WIDTH-1];
      clamp        = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      out_of_range = sum[WIDTH];
      clamp        = INC_NEG ? '0 : '1;
    end
    next_val = (SATURATE == MODE_SAT && out_of_range) ? clamp : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/param_step_counter.sv
// Loadable counter stepping by a fixed signed INC, with wrap or saturate
// policy, sticky overflow flag and a one-cycle out-of-range pulse.
module param_step_counter
  import param_step_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INC         = 1,
  parameter int SIGNED_MODE = MODE_UNSIGNED,
  parameter int SATURATE    = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             wrap_pulse,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] step_val;
  logic             step_oor;

  param_step_addsat #(
    .WIDTH      (WIDTH),
    .INC        (INC),
    .SIGNED_MODE(SIGNED_MODE),
    .SATURATE   (SATURATE)
  ) u_addsat (
    .cur         (out),
    .next_val    (step_val),
    .out_of_range(step_oor)
  );

  // busy is registered alongside state so it tracks COUNT without decoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out        <= '0;
      ovf        <= 1'b0;
      wrap_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (load) begin
        state <= COUNT;
        out   <= load_val;
        ovf   <= 1'b0;
        busy  <= 1'b1;
      end else if (state == COUNT && en) begin
        out <= step_val;
        if (step_oor) begin
          wrap_pulse <= 1'b1;
          ovf        <= 1'b1;
          if (SATURATE == MODE_SAT) begin
            state <= SAT;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
